// File: rtl/vga_monitor_system.sv
// vga_monitor_system: 640x480@60 Hz VGA timing generator with a test-pattern source.
// One 50 MHz clock; pix_en divides it to the 25 MHz pixel rate. The sw input selects
// colour bars (1) or a 32x32 checkerboard (0). Syncs are active low, rgb is 1 bit/channel.
module vga_monitor_system #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       sw,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [2:0] rgb
);

  // Timing landmarks, sized to the 10-bit counters so compares stay width-matched.
  localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam int         BAR_W      = H_VIS / 8;

  logic       pix_en_q,  pix_en_d;
  logic [9:0] hcnt_q,    hcnt_d;
  logic [9:0] vcnt_q,    vcnt_d;
  logic       sw_meta_q, sw_meta_d;
  logic       sw_sel_q,  sw_sel_d;
  logic       hsync_q,   hsync_d;
  logic       vsync_q,   vsync_d;
  logic [2:0] rgb_q,     rgb_d;

  logic [2:0] bar;
  logic [2:0] bar_rgb;
  logic [2:0] chk_rgb;
  logic       visible;

  // Bar index from a chain of threshold compares on hcnt (no divider).
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (hcnt_q >= 10'(i * BAR_W)) begin
        bar = 3'(i);
      end
    end
  end

  // Pattern pixels and visibility for the current counter position.
  always_comb begin
    bar_rgb = ~bar;
    chk_rgb = (hcnt_q[5] ^ vcnt_q[5]) ? 3'b111 : 3'b000;
    visible = (hcnt_q < H_VIS_END) && (vcnt_q < V_VIS_END);
  end

  // Next-state: pixel enable, synchroniser, counters and registered outputs.
  always_comb begin
    pix_en_d  = ~pix_en_q;
    sw_meta_d = sw;
    sw_sel_d  = sw_meta_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    rgb_d     = rgb_q;
    if (pix_en_q) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = 10'd0;
        vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
      // Outputs are decoded from the pre-increment counters: one pixel of lag.
      hsync_d = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
      vsync_d = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
      if (!visible) begin
        rgb_d = 3'b000;
      end else if (sw_sel_q) begin
        rgb_d = bar_rgb;
      end else begin
        rgb_d = chk_rgb;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      pix_en_q  <= 1'b0;
      hcnt_q    <= 10'd0;
      vcnt_q    <= 10'd0;
      sw_meta_q <= 1'b0;
      sw_sel_q  <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= 3'b000;
    end else begin
      pix_en_q  <= pix_en_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      sw_meta_q <= sw_meta_d;
      sw_sel_q  <= sw_sel_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign rgb       = rgb_q;

endmodule

// File: tb/tb_vga_monitor_system.sv
// Bench for vga_monitor_system. Two instances share clock, reset and sw: one with the
// standard 640x480 timing, one with a shortened vertical frame so vsync and frame wrap
// are reached within a short run. A pixel-position reference model predicts every output
// every cycle; pulse widths and periods are also measured directly.
module tb_vga_monitor_system;

  localparam int S_VV = 8, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_FRAME_CYC = (S_VV + S_VF + S_VS + S_VB) * 1600;
  localparam logic [4:0] RST_OUT = 5'b11000;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       sw;
  logic       f_hs, f_vs, s_hs, s_vs;
  logic [2:0] f_rgb, s_rgb;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // model state
  int k;          // clk_in edges since reset release
  int npix;       // pixel updates so far
  bit s0, s1, s2; // sw seen at edges k, k-1, k-2
  logic [4:0] exp_f, exp_s;
  // measurement state
  logic f_hs_prev, s_vs_prev;
  int f_hs_fall, f_hs_low, s_vs_fall, s_vs_low;
  int next_toggle;

  vga_monitor_system dut_full (
    .clk_in(clk_in), .reset_in(reset_in), .sw(sw),
    .vga_hsync(f_hs), .vga_vsync(f_vs), .rgb(f_rgb)
  );

  vga_monitor_system #(.V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)) dut_small (
    .clk_in(clk_in), .reset_in(reset_in), .sw(sw),
    .vga_hsync(s_hs), .vga_vsync(s_vs), .rgb(s_rgb)
  );

  always #10 clk_in = ~clk_in;

  // Expected {hsync, vsync, rgb} for pixel index p since reset.
  function automatic logic [4:0] model(int p, int hv, int hf, int hsy, int hb,
                                       int vv, int vf, int vsy, int vb, bit sel);
    int ht, vt, h, v;
    logic hs, vs;
    logic [2:0] c;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    h  = p % ht;
    v  = (p / ht) % vt;
    hs = !(h >= hv + hf && h < hv + hf + hsy);
    vs = !(v >= vv + vf && v < vv + vf + vsy);
    c  = 3'd0;
    if (h < hv && v < vv) begin
      if (sel) c = 3'(7 - h / (hv / 8));
      else     c = ((((h / 32) + (v / 32)) % 2) == 1) ? 3'd7 : 3'd0;
    end
    return {hs, vs, c};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, expv);
    end
  endtask

  task automatic clear_model();
    k = 0; npix = 0; s0 = 0; s1 = 0; s2 = 0;
    exp_f = RST_OUT; exp_s = RST_OUT;
    f_hs_prev = 1'b1; s_vs_prev = 1'b1;
    f_hs_fall = -1; f_hs_low = -1; s_vs_fall = -1; s_vs_low = -1;
  endtask

  // Advance one clk_in cycle, update the model, compare at the falling edge.
  task automatic step();
    @(negedge clk_in);
    if (!reset_in) begin
      clear_model();
    end else begin
      k++;
      s2 = s1; s1 = s0; s0 = sw;
      if (k % 2 == 0) begin
        exp_f = model(npix, 640, 16, 96, 48, 480, 10, 2, 33, s2);
        exp_s = model(npix, 640, 16, 96, 48, S_VV, S_VF, S_VS, S_VB, s2);
        npix++;
      end
    end
    chk("full_out", {27'd0, f_hs, f_vs, f_rgb}, {27'd0, exp_f});
    chk("small_out", {27'd0, s_hs, s_vs, s_rgb}, {27'd0, exp_s});
    if (reset_in) begin
      if (f_hs_prev && !f_hs) begin
        if (f_hs_fall >= 0) chk("hsync_period", k - f_hs_fall, 1600);
        f_hs_fall = k; f_hs_low = k;
      end
      if (!f_hs_prev && f_hs && f_hs_low >= 0) chk("hsync_width", k - f_hs_low, 192);
      if (s_vs_prev && !s_vs) begin
        if (s_vs_fall >= 0) chk("vsync_period", k - s_vs_fall, S_FRAME_CYC);
        s_vs_fall = k; s_vs_low = k;
      end
      if (!s_vs_prev && s_vs && s_vs_low >= 0) chk("vsync_width", k - s_vs_low, 3200);
      f_hs_prev = f_hs; s_vs_prev = s_vs;
    end
  endtask

  // Run n cycles; with rand_sw set, toggle sw at random intervals.
  task automatic run(int n, bit rand_sw);
    for (int i = 0; i < n; i++) begin
      step();
      if (rand_sw) begin
        next_toggle--;
        if (next_toggle <= 0) begin
          sw = ~sw;
          next_toggle = int'($urandom_range(150, 3000));
        end
      end
    end
  endtask

  initial begin
    reset_in = 1'b0;
    sw = 1'b1;
    next_toggle = int'($urandom_range(150, 3000));
    clear_model();
    // Reset held: outputs at reset values
    repeat (5) step();
    reset_in = 1'b1;
    // Colour bars on the first lines
    run(3500, 1'b0);
    // Random pattern switching across the small frame's vsync and frame wrap
    run(44500, 1'b1);
    // Checkerboard across line 32 of the full-size frame
    sw = 1'b0;
    run(8000, 1'b0);
    run(4000, 1'b1);
    // Mid-line reset pulse, checked asynchronously before any clock edge
    run(int'($urandom_range(100, 1500)), 1'b1);
    reset_in = 1'b0;
    #1;
    chk("async_rst_full", {27'd0, f_hs, f_vs, f_rgb}, {27'd0, RST_OUT});
    chk("async_rst_small", {27'd0, s_hs, s_vs, s_rgb}, {27'd0, RST_OUT});
    repeat (3) step();
    reset_in = 1'b1;
    sw = 1'b1;
    run(4000, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
